qspi_rx_deserializer: RTL and testbench
=======================================

// Module: qspi_rx_deserializer
// PURPOSE
//  Receive-side companion to the QSPI SCLK generator. Oversamples SCLK, CS_N and IO[3:0]
//  in the h_clk domain and detects SCLK rising edges. Shifts in 1/2/4 bits per edge
//  (single/dual/quad), assembles MSB-first bytes and buffers them in a small FWFT FIFO
//  toward the AHB read-data path.
// PARAMETERS
//  SYNC_STAGES  2  synchronizer depth for sclk_in, cs_n_in, io_in (>=2)
//  FIFO_DEPTH   4  receive FIFO entries (power of 2, >=2)
// PORTS
//  h_clk            in   1   system clock; all logic on rising edge
//  h_rst            in   1   asynchronous reset, active-high
//  sclk_in          in   1   SPI clock (CPOL=0, sample on rising edge)
//  cs_n_in          in   1   chip select, active-low
//  io_in            in   4   QSPI data lines IO3..IO0
//  mode_in          in   2   00 single (IO1), 01 dual {IO1,IO0}, 10 quad {IO3..IO0}, 11 = single
//  rx_data_out      out  8   head-of-FIFO byte, valid while rx_valid_out=1
//  rx_valid_out     out  1   FIFO non-empty
//  rx_ready_in      in   1   consumer pop; pop occurs when rx_valid_out & rx_ready_in
//  rx_level_out     out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
//  rx_overflow_out  out  1   sticky: byte completed while FIFO full
//  clr_ovf_in       in   1   clears rx_overflow_out (1-cycle pulse)
//  rx_busy_out      out  1   1 while FSM in ACTIVE
// BEHAVIOUR
//  Reset (h_rst=1, async): FSM=IDLE, sync flops=idle values (sclk 0, cs_n 1, io 0), shift reg 0,
//   bit counter 0, FIFO empty, all outputs 0 (rx_data_out=8'h00).
//  Sync: each input passes SYNC_STAGES flops; sclk_rise = sclk_s & ~sclk_s_d (1 extra flop).
//   Timing req: SCLK high and low >= SYNC_STAGES+1 h_clk cycles (generator clk_div >= SYNC_STAGES).
//  FSM IDLE: wait for synced cs_n=0 -> ACTIVE; on that cycle latch mode_in into mode_q
//   (mode_in ignored while ACTIVE). Shift reg and bit counter cleared.
//  FSM ACTIVE: on each sclk_rise, shift left by W (W=1/2/4 per mode_q), insert sampled synced
//   io bits at LSB, and add W to bit counter (mod 8).
//   When the counter reaches 8: the assembled byte (shift value including current edge's bits)
//   is pushed to the FIFO on the next h_clk edge; counter wraps to 0.
//   Synced cs_n=1 -> IDLE; partial byte (counter!=0) discarded, no push, no flag.
//   A byte completing on the same cycle cs_n rises is still pushed.
//  Latency: rx_valid_out rises 1 h_clk after the completing sclk_rise cycle (if FIFO was empty).
//  FIFO: first-word-fall-through; rx_data_out = entry at read ptr; pointers wrap mod FIFO_DEPTH.
//   Push & pop same cycle: both happen, level unchanged, including when full (no overflow).
//   Push when full without pop: byte dropped, FIFO contents untouched, rx_overflow_out<=1.
//   Pop when empty: ignored. rx_data_out holds last value when empty.
//  Overflow flag: set wins over clr_ovf_in in the same cycle.
//  Reset mid-transfer: everything returns to reset state immediately; partial/buffered data lost.
// TESTING
//  1 Single mode, cs_n low, clk_div=3, shift 0xA5 on IO1 MSB-first -> one push, rx_data_out=8'hA5,
//    rx_valid_out 1 cycle after 8th rise.
//  2 Quad mode, nibbles 3,C,F,0 over 4 edges -> bytes 8'h3C then 8'hF0, level=2, popped in order.
//  3 Dual mode, hold rx_ready_in=0, send FIFO_DEPTH+1 bytes -> level=4, 5th dropped,
//    rx_overflow_out=1 until clr_ovf_in; first 4 bytes intact.
//  4 FIFO full, 5th byte completes same cycle as pop -> no overflow, level stays 4,
//    newest byte at tail.
//  5 Quad mode, cs_n rises after 1 edge (4 bits), then new transfer in single mode 0x81
//    -> only 8'h81 pushed; mode change ignored if toggled mid-ACTIVE.
//  6 Assert h_rst mid-byte with 2 bytes queued -> all outputs 0 asynchronously,
//    next transfer assembles cleanly.

Source files
------------

// File: rtl/qspi_rx_deserializer_if.sv
// Signal bundle between the QSPI receive deserializer and its pins/consumer.
// Master drives the SPI lines and the consumer controls; slave is the deserializer.
interface qspi_rx_deserializer_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          sclk_in;
  logic          cs_n_in;
  logic [3:0]    io_in;
  logic [1:0]    mode_in;
  logic [7:0]    rx_data_out;
  logic          rx_valid_out;
  logic          rx_ready_in;
  logic [LW-1:0] rx_level_out;
  logic          rx_overflow_out;
  logic          clr_ovf_in;
  logic          rx_busy_out;

  modport master (
    output sclk_in, cs_n_in, io_in, mode_in, rx_ready_in, clr_ovf_in,
    input  rx_data_out, rx_valid_out, rx_level_out, rx_overflow_out, rx_busy_out
  );

  modport slave (
    input  sclk_in, cs_n_in, io_in, mode_in, rx_ready_in, clr_ovf_in,
    output rx_data_out, rx_valid_out, rx_level_out, rx_overflow_out, rx_busy_out
  );
endinterface

// File: rtl/qspi_rx_deserializer.sv
// QSPI receive path: synchronizes SCLK/CS_N/IO, shifts 1/2/4 bits per SCLK rise into
// MSB-first bytes and queues them in a first-word-fall-through FIFO.
module qspi_rx_deserializer #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input logic                    h_clk,
  input logic                    h_rst,
  qspi_rx_deserializer_if.slave  bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q;
  logic [3:0]             io_sync_q [SYNC_STAGES];
  logic                   sclk_dly_q;
  logic                   sclk_s, cs_s, sclk_rise, shift_en, byte_done;
  logic [3:0]             io_s;

  logic [1:0] mode_q;
  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q;
  logic [3:0] width_w, cnt_sum;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [7:0]    last_q;
  logic          ovf_q, full, pop, push_ok;

  // Input synchronizers, reset to the idle bus levels
  always_ff @(posedge h_clk or posedge h_rst) begin
    if (h_rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_dly_q  <= 1'b0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) io_sync_q[i] <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk_in};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n_in};
      sclk_dly_q  <= sclk_s;
      io_sync_q[0] <= bus.io_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) io_sync_q[i] <= io_sync_q[i-1];
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign io_s      = io_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;

  always_ff @(posedge h_clk or posedge h_rst) begin
    if (h_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!cs_s) state_d = ACTIVE;
      ACTIVE:  if (cs_s)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.rx_busy_out = (state_q == ACTIVE);
    shift_en        = (state_q == ACTIVE) && sclk_rise;
  end

  always_comb begin
    width_w = 4'd1;
    shift_d = {shift_q[6:0], io_s[1]};
    case (mode_q)
      2'b01: begin width_w = 4'd2; shift_d = {shift_q[5:0], io_s[1:0]}; end
      2'b10: begin width_w = 4'd4; shift_d = {shift_q[3:0], io_s};      end
      default: ;
    endcase
  end

  assign cnt_sum   = {1'b0, cnt_q} + width_w;
  // Byte completes on the edge that brings the count to 8; still pushed if CS_N rises now
  assign byte_done = shift_en && cnt_sum[3];

  always_ff @(posedge h_clk or posedge h_rst) begin
    if (h_rst) begin
      mode_q  <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (state_q == IDLE) begin
      shift_q <= '0;
      cnt_q   <= '0;
      if (!cs_s) mode_q <= bus.mode_in;
    end else if (shift_en) begin
      shift_q <= shift_d;
      cnt_q   <= cnt_sum[2:0];
    end
  end

  assign full    = (level_q == LW'(FIFO_DEPTH));
  assign pop     = (level_q != '0) && bus.rx_ready_in;
  assign push_ok = byte_done && (!full || pop);

  always_ff @(posedge h_clk or posedge h_rst) begin
    if (h_rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      last_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= shift_d;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        last_q   <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push_ok && !pop)      level_q <= level_q + 1'b1;
      else if (!push_ok && pop) level_q <= level_q - 1'b1;
      if (byte_done && full && !pop) ovf_q <= 1'b1;
      else if (bus.clr_ovf_in)       ovf_q <= 1'b0;
    end
  end

  // Empty FIFO keeps presenting the most recently popped byte
  always_comb begin
    bus.rx_valid_out    = (level_q != '0);
    bus.rx_data_out     = (level_q != '0) ? mem_q[rd_ptr_q] : last_q;
    bus.rx_level_out    = level_q;
    bus.rx_overflow_out = ovf_q;
  end
endmodule

// File: tb/tb_qspi_rx_deserializer.sv
// Directed bench for qspi_rx_deserializer: single-byte vector table plus hand-written
// FIFO, overflow, abort and reset sequences.
module tb_qspi_rx_deserializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  qspi_rx_deserializer_if #(.FIFO_DEPTH(4)) bus ();

  qspi_rx_deserializer #(.SYNC_STAGES(2), .FIFO_DEPTH(4)) dut (
    .h_clk (clk),
    .h_rst (rst),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [1:0] mode;
    logic [7:0] tx;
    logic [7:0] exp;
    int         last_act;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] lane(input logic [1:0] m, input logic [3:0] v);
    case (m)
      2'b01:   return {~v[1:0], v[1:0]};
      2'b10:   return v;
      default: return {~v[0], ~v[0], v[0], ~v[0]};
    endcase
  endfunction

  // One SCLK period, 3 h_clk low + 3 high; act: 1 latency check, 2 pop at push, 3 clr at push
  task automatic sclk_edge(input logic [3:0] io, input int act);
    bus.io_in   = io;
    bus.sclk_in = 1'b0;
    repeat (3) @(negedge clk);
    bus.sclk_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    if (act == 1) check("latency_before", bus.rx_valid_out, 1'b0);
    if (act == 2) bus.rx_ready_in = 1'b1;
    if (act == 3) bus.clr_ovf_in = 1'b1;
    @(negedge clk);
    bus.rx_ready_in = 1'b0;
    bus.clr_ovf_in  = 1'b0;
    if (act == 1) check("latency_after", bus.rx_valid_out, 1'b1);
  endtask

  task automatic send_byte(input logic [1:0] m, input logic [7:0] b, input int last_act);
    int unsigned w;
    int unsigned n;
    logic [7:0]  t;
    w = (m == 2'b01) ? 2 : (m == 2'b10) ? 4 : 1;
    n = 8 / w;
    for (int unsigned e = 0; e < n; e++) begin
      t = b >> (8 - w * (e + 1));
      sclk_edge(lane(m, t[3:0] & 4'((1 << w) - 1)), (e == n - 1) ? last_act : 0);
    end
  endtask

  task automatic start_frame(input logic [1:0] m);
    @(negedge clk);
    bus.mode_in = m;
    bus.cs_n_in = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic end_frame();
    @(negedge clk);
    bus.sclk_in = 1'b0;
    bus.cs_n_in = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    check(name, bus.rx_data_out, exp);
    bus.rx_ready_in = 1'b1;
    @(negedge clk);
    bus.rx_ready_in = 1'b0;
  endtask

  task automatic clr_pulse();
    bus.clr_ovf_in = 1'b1;
    @(negedge clk);
    bus.clr_ovf_in = 1'b0;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{mode: 2'b00, tx: 8'hA5, exp: 8'hA5, last_act: 1};
    vecs[1] = '{mode: 2'b01, tx: 8'h3C, exp: 8'h3C, last_act: 0};
    vecs[2] = '{mode: 2'b10, tx: 8'hF0, exp: 8'hF0, last_act: 1};
    vecs[3] = '{mode: 2'b11, tx: 8'h81, exp: 8'h81, last_act: 0};
    vecs[4] = '{mode: 2'b01, tx: 8'h5A, exp: 8'h5A, last_act: 1};
    vecs[5] = '{mode: 2'b10, tx: 8'hC3, exp: 8'hC3, last_act: 0};

    bus.sclk_in = 1'b0; bus.cs_n_in = 1'b1; bus.io_in = 4'h0; bus.mode_in = 2'b00;
    bus.rx_ready_in = 1'b0; bus.clr_ovf_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", bus.rx_valid_out, 1'b0);
    check("rst_data", bus.rx_data_out, 8'h00);
    check("rst_level", bus.rx_level_out, 3'd0);
    check("rst_ovf", bus.rx_overflow_out, 1'b0);
    check("rst_busy", bus.rx_busy_out, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single-byte vectors across all modes
    for (int i = 0; i < 6; i++) begin
      start_frame(vecs[i].mode);
      check("vec_busy", bus.rx_busy_out, 1'b1);
      send_byte(vecs[i].mode, vecs[i].tx, vecs[i].last_act);
      end_frame();
      check("vec_valid", bus.rx_valid_out, 1'b1);
      check("vec_level", bus.rx_level_out, 3'd1);
      check("vec_idle", bus.rx_busy_out, 1'b0);
      pop_check("vec_data", vecs[i].exp);
      check("vec_empty", bus.rx_valid_out, 1'b0);
    end

    // Quad nibbles 3,C,F,0 -> 3C, F0
    start_frame(2'b10);
    sclk_edge(4'h3, 0); sclk_edge(4'hC, 0); sclk_edge(4'hF, 0); sclk_edge(4'h0, 0);
    end_frame();
    check("quad_level", bus.rx_level_out, 3'd2);
    pop_check("quad_b0", 8'h3C);
    pop_check("quad_b1", 8'hF0);
    check("quad_empty", bus.rx_valid_out, 1'b0);
    check("quad_hold", bus.rx_data_out, 8'hF0);

    // Dual-mode overflow, sticky flag, set beats clear
    start_frame(2'b01);
    send_byte(2'b01, 8'h11, 0); send_byte(2'b01, 8'h22, 0);
    send_byte(2'b01, 8'h33, 0); send_byte(2'b01, 8'h44, 0);
    check("ovf_pre", bus.rx_overflow_out, 1'b0);
    send_byte(2'b01, 8'h55, 0);
    check("ovf_level", bus.rx_level_out, 3'd4);
    check("ovf_set", bus.rx_overflow_out, 1'b1);
    repeat (3) @(negedge clk);
    check("ovf_sticky", bus.rx_overflow_out, 1'b1);
    clr_pulse();
    check("ovf_clr", bus.rx_overflow_out, 1'b0);
    send_byte(2'b01, 8'h66, 3);
    check("ovf_set_wins", bus.rx_overflow_out, 1'b1);
    clr_pulse();
    end_frame();
    check("ovf_clr2", bus.rx_overflow_out, 1'b0);
    pop_check("ovf_b0", 8'h11);
    pop_check("ovf_b1", 8'h22);
    pop_check("ovf_b2", 8'h33);
    pop_check("ovf_b3", 8'h44);
    check("ovf_empty", bus.rx_level_out, 3'd0);

    // Full FIFO, push coincides with pop
    start_frame(2'b10);
    send_byte(2'b10, 8'hA1, 0); send_byte(2'b10, 8'hA2, 0);
    send_byte(2'b10, 8'hA3, 0); send_byte(2'b10, 8'hA4, 0);
    send_byte(2'b10, 8'h5E, 2);
    end_frame();
    check("pp_ovf", bus.rx_overflow_out, 1'b0);
    check("pp_level", bus.rx_level_out, 3'd4);
    pop_check("pp_b0", 8'hA2);
    pop_check("pp_b1", 8'hA3);
    pop_check("pp_b2", 8'hA4);
    pop_check("pp_b3", 8'h5E);
    check("pp_empty", bus.rx_valid_out, 1'b0);

    // Aborted quad partial, then single 0x81 with mode toggled mid-byte
    start_frame(2'b10);
    sclk_edge(4'hF, 0);
    end_frame();
    check("abort_valid", bus.rx_valid_out, 1'b0);
    check("abort_ovf", bus.rx_overflow_out, 1'b0);
    start_frame(2'b00);
    for (int i = 7; i >= 0; i--) begin
      if (i == 3) bus.mode_in = 2'b10;
      sclk_edge(lane(2'b00, {3'b000, ((8'h81 >> i) & 8'h01) != 8'h00}), 0);
    end
    end_frame();
    check("mode_lock_level", bus.rx_level_out, 3'd1);
    pop_check("mode_lock_data", 8'h81);

    // Async reset with two bytes queued and a partial third
    start_frame(2'b10);
    send_byte(2'b10, 8'h12, 0); send_byte(2'b10, 8'h34, 0);
    sclk_edge(4'h7, 0);
    check("prerst_level", bus.rx_level_out, 3'd2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", bus.rx_valid_out, 1'b0);
    check("arst_data", bus.rx_data_out, 8'h00);
    check("arst_level", bus.rx_level_out, 3'd0);
    check("arst_busy", bus.rx_busy_out, 1'b0);
    bus.cs_n_in = 1'b1;
    bus.sclk_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    start_frame(2'b00);
    send_byte(2'b00, 8'h6D, 0);
    end_frame();
    check("postrst_level", bus.rx_level_out, 3'd1);
    check("postrst_ovf", bus.rx_overflow_out, 1'b0);
    pop_check("postrst_data", 8'h6D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
